lsync_preamble_gen: RTL and testbench
=====================================

Name: lsync_preamble_gen

Overview:
Transmit-side long-training-sequence source, the producer counterpart of the long-sync correlator in the receive chain. On a start command it emits the quantized 2-bit I/Q long preamble sample-by-sample over a valid/ready handshake:
- cyclic prefix (last CP_LEN samples of the symbol);
- then NUM_REP full repetitions of the SYM_LEN-sample symbol.

It feeds the TX sample path and serves as the loopback stimulus source for the Lsync receiver.

Parameters:
CP_LEN, 32, cyclic-prefix length in samples (1..SYM_LEN)
SYM_LEN, 64, LTS symbol length in samples (power of 2)
NUM_REP, 2, number of full symbol repetitions after the CP (1..4)
ROM_I, 128'h0…, packed I samples: entry k at bits [2k+1:2k], signed 2-bit, MATLAB-generated
ROM_Q, 128'h0…, packed Q samples, same packing

Ports:
CLK  in  1  clock, rising edge
a_RST_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request to emit one preamble; honoured only in IDLE
abort  in  1  synchronous cancel; returns to IDLE without done
out_ready  in  1  downstream accepts the current sample this cycle
output_strobe  out  1  I_out/Q_out/out_idx valid
I_out  out  2  signed quantized I sample
Q_out  out  2  signed quantized Q sample
out_idx  out  log2(SYM_LEN)  ROM index of the current sample
busy  out  1  high in CP or SYM state
done  out  1  1-cycle pulse after the last sample is accepted

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (a_RST_n). All outputs are registered.
- Reset values: output_strobe=0, I_out=0, Q_out=0, out_idx=0, busy=0, done=0. State=IDLE, rep_cnt=0.
- FSM states: IDLE, CP, SYM, DONE.
- IDLE:
  - start=1 -> CP next cycle.
  - In that first CP cycle: output_strobe=1, out_idx=SYM_LEN-CP_LEN, I/Q=ROM[idx].
  - Latency from start to first valid sample is 1 cycle.
- Handshake: a sample transfers on a cycle with output_strobe=1 and out_ready=1.
  - On transfer, the next sample is presented the following cycle. Back-to-back transfers are allowed, one sample per clock.
  - With output_strobe=1 and out_ready=0, I_out/Q_out/out_idx hold stable.
  - out_ready is ignored while output_strobe=0.
- CP state:
  - idx runs SYM_LEN-CP_LEN .. SYM_LEN-1.
  - Transfer at idx=SYM_LEN-1 -> SYM state, idx wraps to 0, rep_cnt=0.
- SYM state:
  - idx runs 0..SYM_LEN-1.
  - Transfer at idx=SYM_LEN-1 with rep_cnt<NUM_REP-1: idx wraps to 0, rep_cnt++, no bubble.
  - Transfer at idx=SYM_LEN-1 with rep_cnt=NUM_REP-1: go to DONE, output_strobe=0 next cycle.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start in DONE is ignored (not queued).
- Total samples per preamble = CP_LEN + NUM_REP*SYM_LEN (160 with defaults).
- busy=1 in CP/SYM, including stall cycles. start while busy is ignored.
- abort:
  - In CP/SYM: next cycle IDLE, output_strobe=0, busy=0, done=0, counters cleared.
  - abort has priority over a simultaneous transfer and over start.
  - abort in IDLE/DONE: no effect, except that in DONE the done pulse still completes.
- Reset mid-operation: outputs clear immediately (asynchronously). After deassertion the block sits in IDLE.
- I_out/Q_out are ROM values verbatim (signed 2-bit, range -2..+1). No arithmetic is applied.

Test Plan:
1. Reset then start with out_ready=1, default params -> first strobe 1 cycle after start, out_idx=32; strobe held 160 consecutive cycles; idx sequence 32..63, 0..63, 0..63; done pulses 1 cycle after the 160th transfer; busy low same cycle as done.
2. ROM_I entry0=2'b01, entry63=2'b11, ROM_Q entry0=2'b00 -> sample #33 (idx 0) shows I=+1, Q=0; sample #32 (idx 63) shows I=-1.
3. Random out_ready (~50%) -> data/idx stable during every stall; exactly 160 transfers, no duplicates or skips; done once.
4. start pulsed again at sample 50 and in the DONE cycle -> ignored; idx sequence unaffected; a start in IDLE afterwards launches a new preamble at idx 32.
5. abort at transfer #70 (SYM, idx 37) with out_ready=1 -> strobe=0 next cycle, no done; a subsequent start restarts at idx 32.
6. a_RST_n asserted mid-SYM, asynchronous to CLK -> strobe/busy/I/Q drop immediately; after release, no output until start.

Source files
------------

// File: rtl/lsync_preamble_gen.sv
// Long-training-sequence source: emits the cyclic prefix and then NUM_REP full
// symbols of a quantized 2-bit I/Q ROM over a valid/ready handshake.
module lsync_preamble_gen #(
  parameter int                   CP_LEN  = 32,
  parameter int                   SYM_LEN = 64,
  parameter int                   NUM_REP = 2,
  parameter logic [2*SYM_LEN-1:0] ROM_I   = '0,
  parameter logic [2*SYM_LEN-1:0] ROM_Q   = '0
) (
  input  logic                       CLK,
  input  logic                       a_RST_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       out_ready,
  output logic                       output_strobe,
  output logic signed [1:0]          I_out,
  output logic signed [1:0]          Q_out,
  output logic [$clog2(SYM_LEN)-1:0] out_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(SYM_LEN);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(SYM_LEN - CP_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SYM_LEN - 1);
  localparam logic [1:0]       REP_LAST  = 2'(NUM_REP - 1);

  typedef enum logic [1:0] {S_IDLE, S_CP, S_SYM, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [1:0]             rep_cnt, rep_nxt;
  logic                   xfer;
  logic                   strobe_nxt, busy_nxt, done_nxt;
  logic signed [1:0]      i_nxt, q_nxt;

  function automatic logic signed [1:0] rom_sample(input logic [2*SYM_LEN-1:0] rom,
                                                   input logic [IDX_W-1:0]     k);
    return rom[{k, 1'b0} +: 2];
  endfunction

  assign xfer = output_strobe & out_ready;

  // State register: FSM, counters and the registered output stage
  always_ff @(posedge CLK or negedge a_RST_n) begin
    if (!a_RST_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      rep_cnt       <= '0;
      output_strobe <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      I_out         <= '0;
      Q_out         <= '0;
      out_idx       <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      rep_cnt       <= rep_nxt;
      output_strobe <= strobe_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      I_out         <= i_nxt;
      Q_out         <= q_nxt;
      out_idx       <= idx_nxt;
    end
  end

  // Next state: abort outranks a transfer; a stall simply holds idx
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rep_nxt   = rep_cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_CP;
          idx_nxt   = IDX_FIRST;
          rep_nxt   = '0;
        end
      end
      S_CP, S_SYM: begin
        if (abort) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
          rep_nxt   = '0;
        end else if (xfer) begin
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            if (state == S_CP) begin
              state_nxt = S_SYM;
              rep_nxt   = '0;
            end else if (rep_cnt == REP_LAST) begin
              state_nxt = S_DONE;
              rep_nxt   = '0;
            end else begin
              rep_nxt = rep_cnt + 2'd1;
            end
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the block registered
  always_comb begin
    strobe_nxt = (state_nxt == S_CP) || (state_nxt == S_SYM);
    busy_nxt   = strobe_nxt;
    done_nxt   = (state_nxt == S_DONE);
    i_nxt      = '0;
    q_nxt      = '0;
    if (strobe_nxt) begin
      i_nxt = rom_sample(ROM_I, idx_nxt);
      q_nxt = rom_sample(ROM_Q, idx_nxt);
    end
  end

endmodule

// File: tb/tb_lsync_preamble_gen.sv
// Scoreboard bench for lsync_preamble_gen: starts push the expected sample
// stream, a negedge monitor pops and compares each presented/accepted sample.
module tb_lsync_preamble_gen;

  localparam int CP    = 32;
  localparam int SYM   = 64;
  localparam int REP   = 2;
  localparam int TOTAL = CP + REP * SYM;
  localparam logic [127:0] ROM_I_P = 128'hD2B4_1E97_63A5_0F3C_8B7E_2D49_A61C_5E71;
  localparam logic [127:0] ROM_Q_P = 128'h6C3A_95E1_0B7D_42F8_A913_5C6E_D084_27BC;

  logic              CLK = 1'b0;
  logic              a_RST_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b0;
  logic              output_strobe;
  logic signed [1:0] I_out, Q_out;
  logic [5:0]        out_idx;
  logic              busy, done;

  lsync_preamble_gen #(
    .CP_LEN(CP), .SYM_LEN(SYM), .NUM_REP(REP), .ROM_I(ROM_I_P), .ROM_Q(ROM_Q_P)
  ) dut (
    .CLK(CLK), .a_RST_n(a_RST_n), .start(start), .abort(abort), .out_ready(out_ready),
    .output_strobe(output_strobe), .I_out(I_out), .Q_out(Q_out), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]        idx;
    logic signed [1:0] i;
    logic signed [1:0] q;
    bit                last;
  } smp_t;

  smp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          xfer_cnt = 0;
  bit          rnd_ready = 0;
  logic [127:0] rom_i = ROM_I_P;
  logic [127:0] rom_q = ROM_Q_P;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, $signed(act), $signed(exp), $time);
  endtask

  // n-th sample of a preamble: CP is the tail of the symbol, then whole symbols
  function automatic smp_t model(input int n);
    smp_t s;
    int   k;
    k      = (n < CP) ? (SYM - CP + n) : ((n - CP) % SYM);
    s.idx  = 6'(k);
    s.i    = rom_i[2*k +: 2];
    s.q    = rom_q[2*k +: 2];
    s.last = (n == TOTAL - 1);
    return s;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit                done_due = 0, quiet_due = 0, prev_stall = 0;
  logic [5:0]        prev_idx;
  logic signed [1:0] prev_i, prev_q;

  always @(negedge CLK) begin
    if (!a_RST_n) begin
      exp_q.delete();
      done_due   = 0;
      quiet_due  = 0;
      prev_stall = 0;
    end else begin
      if (done_due || done) chk("done_pulse", done, done_due);
      if (done) chk("busy_in_done", busy, 0);
      done_due = 0;
      if (quiet_due) chk("abort_quiet", {output_strobe, busy, done}, 0);
      quiet_due = 0;
      chk("busy_eq_strobe", busy, output_strobe);
      if (prev_stall && output_strobe)
        chk("stall_hold", {out_idx, I_out, Q_out}, {prev_idx, prev_i, prev_q});
      if (output_strobe) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", output_strobe, 0);
        end else begin
          chk("idx", out_idx, exp_q[0].idx);
          chk("I", I_out, exp_q[0].i);
          chk("Q", Q_out, exp_q[0].q);
          if (abort) begin
            exp_q.delete();
            quiet_due = 1;
          end else if (out_ready) begin
            if (exp_q[0].last) done_due = 1;
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end
      prev_stall = output_strobe && !out_ready && !abort;
      prev_idx   = out_idx;
      prev_i     = I_out;
      prev_q     = Q_out;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_preamble();
    for (int n = 0; n < TOTAL; n++) exp_q.push_back(model(n));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_strobe", output_strobe, 1);
    chk("first_idx", out_idx, SYM - CP);
  endtask

  task automatic wait_xfer(input int base, input int n);
    int t = 0;
    while ((xfer_cnt - base) < n && t < 2000) begin step(); t++; end
    if (t >= 2000) chk("xfer_timeout", xfer_cnt - base, n);
  endtask

  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 2000) begin step(); t++; end
    if (t >= 2000) chk("done_timeout", done, 1);
  endtask

  int base;

  initial begin
    // reset values
    repeat (3) @(negedge CLK);
    chk("rst_strobe", output_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_iq_idx", {I_out, Q_out, out_idx}, 0);
    @(posedge CLK); #3; a_RST_n = 1'b1;
    step(); step();
    chk("idle_strobe", output_strobe, 0);

    // continuous ready, full preamble, explicit ROM corner samples
    out_ready = 1'b1;
    base = xfer_cnt;
    start_preamble();
    wait_xfer(base, 31);
    chk("s32_idx", out_idx, 63);
    chk("s32_I", I_out, -2'sd1);
    step();
    chk("s33_idx", out_idx, 0);
    chk("s33_I", I_out, 2'sd1);
    chk("s33_Q", Q_out, 0);
    wait_done();
    chk("count_t1", xfer_cnt - base, TOTAL);
    step();

    // random backpressure
    rnd_ready = 1;
    repeat (2) begin
      base = xfer_cnt;
      start_preamble();
      wait_done();
      chk("count_rnd", xfer_cnt - base, TOTAL);
      repeat ($urandom_range(1, 4)) step();
    end

    // start while busy and during DONE is ignored
    rnd_ready = 0; out_ready = 1'b1;
    base = xfer_cnt;
    start_preamble();
    wait_xfer(base, 50);
    start = 1'b1; step(); start = 1'b0;
    wait_done();
    start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    chk("count_t4", xfer_cnt - base, TOTAL);
    chk("no_relaunch", output_strobe, 0);
    base = xfer_cnt;
    start_preamble();
    wait_done();
    step();

    // abort mid-symbol, then restart
    base = xfer_cnt;
    start_preamble();
    wait_xfer(base, 69);
    chk("abort_idx", out_idx, 37);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_strobe", output_strobe, 0);
    repeat (5) step();
    chk("abort_count", xfer_cnt - base, 69);
    base = xfer_cnt;
    start_preamble();
    wait_done();
    step();

    // asynchronous reset mid-symbol
    rnd_ready = 1;
    base = xfer_cnt;
    start_preamble();
    wait_xfer(base, 80);
    #3 a_RST_n = 1'b0;
    #1;
    chk("arst_strobe", output_strobe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_iq", {I_out, Q_out, out_idx}, 0);
    repeat (2) @(posedge CLK);
    #3 a_RST_n = 1'b1;
    rnd_ready = 0; out_ready = 1'b1;
    repeat (20) step();
    chk("post_rst_idle", {output_strobe, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
